// File: rtl/priv_isa_types_pkg.sv
// Shared constants, types and helpers for the RV32 HPM counter bank.
package priv_isa_types_pkg;

  // CSR address bases for the counter address space
  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] MHPMEVENT_BASE     = 12'h323;
  localparam logic [11:0] MHPMCOUNTER_BASE   = 12'hB03;
  localparam logic [11:0] MHPMCOUNTERH_BASE  = 12'hB83;
  localparam logic [11:0] HPMCOUNTER_BASE    = 12'hC03;
  localparam logic [11:0] HPMCOUNTERH_BASE   = 12'hC83;

  // Architectural maximum number of HPM counters (indices 3..31)
  localparam int HPM_MAX   = 29;
  localparam int HPM_EVT_W = 5;

  // Architectural view of an mhpmeventN register
  typedef struct packed {
    logic                   of;
    logic [30-HPM_EVT_W:0]  reserved;
    logic [HPM_EVT_W-1:0]   sel;
  } hpm_event_t;

  // Select one sampled event by code; codes beyond 31 never fire
  function automatic logic ev_pick(input logic [31:0] evq, input logic [31:0] code);
    logic hit;
    if (code < 32'd32) begin
      hit = evq[code[4:0]];
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/priv_hpm_counter.sv
// One HPM counter: CNT_W-bit count with CSR write ports and a sticky overflow flag.
module priv_hpm_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  input  logic             of_wr,
  input  logic             of_wdata,
  output logic [CNT_W-1:0] count,
  output logic             of
);

  logic [CNT_W-1:0] cnt_nxt_s;
  logic             wrap_s;
  logic             of_nxt_s;

  // A CSR write to either half wins over a same-cycle increment
  always_comb begin
    cnt_nxt_s = count;
    if (wr_lo || wr_hi) begin
      if (wr_lo) begin
        cnt_nxt_s[31:0] = wdata;
      end else begin
        cnt_nxt_s[31:0] = count[31:0];
      end
      if (wr_hi) begin
        cnt_nxt_s[CNT_W-1:32] = wdata[CNT_W-33:0];
      end else begin
        cnt_nxt_s[CNT_W-1:32] = count[CNT_W-1:32];
      end
    end else if (inc) begin
      cnt_nxt_s = count + CNT_W'(1);
    end else begin
      cnt_nxt_s = count;
    end
  end

  // Wrap only counts when the increment actually lands; a SW OF write overrides it
  assign wrap_s   = inc & ~wr_lo & ~wr_hi & (&count);
  assign of_nxt_s = of_wr ? of_wdata : (of | wrap_s);

  // Counter and overflow state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      of    <= 1'b0;
    end else begin
      count <= cnt_nxt_s;
      of    <= of_nxt_s;
    end
  end

endmodule

// File: rtl/priv_hpm_counters.sv
// Bank of RV32 HPM counters 3..31 with event selectors, mcountinhibit and
// Sscofpmf-style overflow flags; serves the HPM CSR address space.
module priv_hpm_counters
  import priv_isa_types_pkg::*;
#(
  parameter int NUM_HPM = 29,
  parameter int CNT_W   = 64,
  parameter int EVT_W   = 5
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [28:0] hpm_inc,
  input  logic        inst_ret,
  input  logic [11:0] csr_addr,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic        csr_hit,
  output logic [31:0] csr_rdata,
  output logic        ovf_irq
);

  localparam logic [31:0] INH_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

  logic [31:0]        ev_q;
  logic [31:0]        inh_r;
  logic [EVT_W-1:0]   sel_r [HPM_MAX];
  logic [63:0]        cnt_all [HPM_MAX];
  logic [HPM_MAX-1:0] of_all;

  logic [11:0] evt_off_s, lo_off_s, hi_off_s, ulo_off_s, uhi_off_s;
  logic        is_inh_s, is_evt_s, is_lo_s, is_hi_s, is_ulo_s, is_uhi_s;
  logic [HPM_MAX-1:0] wr_evt_s, wr_lo_s, wr_hi_s;

  // Address decode: each window holds HPM_MAX slots, unimplemented ones still hit
  assign evt_off_s = csr_addr - MHPMEVENT_BASE;
  assign lo_off_s  = csr_addr - MHPMCOUNTER_BASE;
  assign hi_off_s  = csr_addr - MHPMCOUNTERH_BASE;
  assign ulo_off_s = csr_addr - HPMCOUNTER_BASE;
  assign uhi_off_s = csr_addr - HPMCOUNTERH_BASE;

  assign is_inh_s = (csr_addr == MCOUNTINHIBIT_ADDR);
  assign is_evt_s = (evt_off_s < 12'(HPM_MAX));
  assign is_lo_s  = (lo_off_s  < 12'(HPM_MAX));
  assign is_hi_s  = (hi_off_s  < 12'(HPM_MAX));
  assign is_ulo_s = (ulo_off_s < 12'(HPM_MAX));
  assign is_uhi_s = (uhi_off_s < 12'(HPM_MAX));

  // Per-slot write strobes; user shadows are read-only and never strobe
  always_comb begin
    for (int k = 0; k < HPM_MAX; k++) begin
      wr_evt_s[k] = csr_wen & is_evt_s & (evt_off_s == 12'(k));
      wr_lo_s[k]  = csr_wen & is_lo_s  & (lo_off_s  == 12'(k));
      wr_hi_s[k]  = csr_wen & is_hi_s  & (hi_off_s  == 12'(k));
    end
  end

  // Stage 1: sample event strobes indexed by event code (0 off, 1 retire, 2 cycle)
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ev_q <= 32'd0;
    end else begin
      ev_q <= {hpm_inc, 1'b1, inst_ret, 1'b0};
    end
  end

  // mcountinhibit: only implemented counter bits hold state
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      inh_r <= 32'd0;
    end else if (csr_wen && is_inh_s) begin
      inh_r <= csr_wdata & INH_MASK;
    end else begin
      inh_r <= inh_r;
    end
  end

  // Event selectors; slots beyond NUM_HPM stay at zero
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < HPM_MAX; k++) begin
        sel_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_HPM; k++) begin
        if (wr_evt_s[k]) begin
          sel_r[k] <= csr_wdata[EVT_W-1:0];
        end else begin
          sel_r[k] <= sel_r[k];
        end
      end
    end
  end

  // Stage 2: one counter per implemented slot, tie off the rest
  for (genvar k = 0; k < HPM_MAX; k++) begin : g_cnt
    if (k < NUM_HPM) begin : g_impl
      logic [CNT_W-1:0] count_s;
      logic             of_s;
      logic             inc_s;

      assign inc_s = ev_pick(ev_q, 32'(sel_r[k])) & ~inh_r[k+3];

      priv_hpm_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (CLK),
        .rst_n    (nRST),
        .inc      (inc_s),
        .wr_lo    (wr_lo_s[k]),
        .wr_hi    (wr_hi_s[k]),
        .wdata    (csr_wdata),
        .of_wr    (wr_evt_s[k]),
        .of_wdata (csr_wdata[31]),
        .count    (count_s),
        .of       (of_s)
      );

      assign cnt_all[k] = 64'(count_s);
      assign of_all[k]  = of_s;
    end else begin : g_none
      assign cnt_all[k] = 64'd0;
      assign of_all[k]  = 1'b0;
    end
  end

  // Read mux: combinational from state, zero for anything not owned here
  always_comb begin
    csr_hit   = 1'b0;
    csr_rdata = 32'd0;
    if (is_inh_s) begin
      csr_hit   = 1'b1;
      csr_rdata = inh_r;
    end else if (is_evt_s) begin
      csr_hit   = 1'b1;
      csr_rdata = {of_all[evt_off_s[4:0]], {(31-EVT_W){1'b0}}, sel_r[evt_off_s[4:0]]};
    end else if (is_lo_s) begin
      csr_hit   = 1'b1;
      csr_rdata = cnt_all[lo_off_s[4:0]][31:0];
    end else if (is_hi_s) begin
      csr_hit   = 1'b1;
      csr_rdata = cnt_all[hi_off_s[4:0]][63:32];
    end else if (is_ulo_s) begin
      csr_hit   = 1'b1;
      csr_rdata = cnt_all[ulo_off_s[4:0]][31:0];
    end else if (is_uhi_s) begin
      csr_hit   = 1'b1;
      csr_rdata = cnt_all[uhi_off_s[4:0]][63:32];
    end else begin
      csr_hit   = 1'b0;
      csr_rdata = 32'd0;
    end
  end

  // Overflow interrupt level, registered one cycle behind the flags
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ovf_irq <= 1'b0;
    end else begin
      ovf_irq <= |of_all;
    end
  end

endmodule

// File: tb/tb_priv_hpm_counters.sv
// Self-checking bench for priv_hpm_counters: directed scenarios followed by a
// randomized phase, all checked against a cycle-level reference model.
module tb_priv_hpm_counters;

  logic        CLK;
  logic        nRST;
  logic [28:0] hpm_inc;
  logic        inst_ret;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        ovf_irq;

  priv_hpm_counters dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .hpm_inc   (hpm_inc),
    .inst_ret  (inst_ret),
    .csr_addr  (csr_addr),
    .csr_wen   (csr_wen),
    .csr_wdata (csr_wdata),
    .csr_hit   (csr_hit),
    .csr_rdata (csr_rdata),
    .ovf_irq   (ovf_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state of counters 3..31
  logic [63:0] cnt_m [32];
  logic [4:0]  sel_m [32];
  bit          of_m  [32];
  logic [31:0] inh_m;
  bit          ovf_m;
  // Event strobes as seen at the previous edge (counted at the next one)
  logic [28:0] samp_hpm;
  bit          samp_ret;
  bit          samp_cyc;

  function automatic bit ev_of(input logic [4:0] code);
    case (code)
      5'd0:    return 1'b0;
      5'd1:    return samp_ret;
      5'd2:    return samp_cyc;
      default: return samp_hpm[code - 5'd3];
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs presented now
  task automatic model_edge();
    bit any_of;
    bit wr_cnt;
    if (!nRST) begin
      for (int n = 3; n < 32; n++) begin
        cnt_m[n] = 64'd0; sel_m[n] = 5'd0; of_m[n] = 1'b0;
      end
      inh_m = 32'd0; ovf_m = 1'b0;
      samp_hpm = 29'd0; samp_ret = 1'b0; samp_cyc = 1'b0;
      return;
    end
    any_of = 1'b0;
    for (int n = 3; n < 32; n++) any_of |= of_m[n];
    for (int n = 3; n < 32; n++) begin
      wr_cnt = csr_wen && (csr_addr == 12'(32'hB00 + n) || csr_addr == 12'(32'hB80 + n));
      if (ev_of(sel_m[n]) && !inh_m[n] && !wr_cnt) begin
        if (cnt_m[n] == 64'hFFFF_FFFF_FFFF_FFFF) of_m[n] = 1'b1;
        cnt_m[n] = cnt_m[n] + 64'd1;
      end
    end
    if (csr_wen) begin
      if (csr_addr == 12'h320) inh_m = csr_wdata & 32'hFFFF_FFF8;
      for (int n = 3; n < 32; n++) begin
        if (csr_addr == 12'(32'h320 + n)) begin
          sel_m[n] = csr_wdata[4:0];
          of_m[n]  = csr_wdata[31];
        end
        if (csr_addr == 12'(32'hB00 + n)) cnt_m[n][31:0]  = csr_wdata;
        if (csr_addr == 12'(32'hB80 + n)) cnt_m[n][63:32] = csr_wdata;
      end
    end
    ovf_m    = any_of;
    samp_hpm = hpm_inc;
    samp_ret = inst_ret;
    samp_cyc = 1'b1;
  endtask

  // One full clock period; the model sees exactly what the DUT samples
  task automatic step();
    model_edge();
    CLK = 1'b1;
    #5;
    CLK = 1'b0;
    #5;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic h);
    csr_addr = a;
    #1;
    d = csr_rdata;
    h = csr_hit;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    step();
    csr_wen   = 1'b0;
  endtask

  // Compare every owned register against the model
  task automatic check_all(input string ph);
    logic [31:0] d;
    logic        h;
    for (int n = 3; n < 32; n++) begin
      rd(12'(32'hB00 + n), d, h);
      chk($sformatf("%s lo%0d", ph, n), d, cnt_m[n][31:0]);
      chk($sformatf("%s hit%0d", ph, n), {31'd0, h}, 32'd1);
      rd(12'(32'hB80 + n), d, h);
      chk($sformatf("%s hi%0d", ph, n), d, cnt_m[n][63:32]);
      rd(12'(32'hC00 + n), d, h);
      chk($sformatf("%s ulo%0d", ph, n), d, cnt_m[n][31:0]);
      rd(12'(32'hC80 + n), d, h);
      chk($sformatf("%s uhi%0d", ph, n), d, cnt_m[n][63:32]);
      rd(12'(32'h320 + n), d, h);
      chk($sformatf("%s evt%0d", ph, n), d, {of_m[n], 26'd0, sel_m[n]});
    end
    rd(12'h320, d, h);
    chk($sformatf("%s inhibit", ph), d, inh_m);
    chk($sformatf("%s ovf_irq", ph), {31'd0, ovf_irq}, {31'd0, ovf_m});
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    int          r;
    int          n;

    CLK = 1'b0; nRST = 1'b0; hpm_inc = 29'd0; inst_ret = 1'b0;
    csr_addr = 12'd0; csr_wen = 1'b0; csr_wdata = 32'd0;
    step();
    step();
    nRST = 1'b1;
    check_all("reset");

    // 1: five hpm_inc[0] pulses on counter 3
    wr(12'h323, 32'd3);
    hpm_inc = 29'd1;
    repeat (5) step();
    hpm_inc = 29'd0;
    step();
    step();
    rd(12'hB03, d, h); chk("t1 cnt3 lo", d, 32'd5);
    rd(12'hB83, d, h); chk("t1 cnt3 hi", d, 32'd0);
    check_all("t1");

    // 2: every-cycle counter with an inhibit window
    wr(12'h324, 32'd2);
    wr(12'h320, 32'h10);
    repeat (10) step();
    wr(12'h320, 32'd0);
    repeat (10) step();
    rd(12'hB04, d, h);
    chk("t2 cnt4 in 9..11", {31'd0, (d >= 32'd9 && d <= 32'd11)}, 32'd1);
    check_all("t2");

    // 3: wrap from all-ones sets OF5, irq one cycle later, SW clear
    wr(12'hB05, 32'hFFFF_FFFF);
    wr(12'hB85, 32'hFFFF_FFFF);
    wr(12'h325, 32'd1);
    inst_ret = 1'b1;
    step();
    inst_ret = 1'b0;
    step();
    rd(12'hB05, d, h); chk("t3 cnt5 lo", d, 32'd0);
    rd(12'hB85, d, h); chk("t3 cnt5 hi", d, 32'd0);
    rd(12'h325, d, h); chk("t3 evt5 of", d, 32'h8000_0001);
    chk("t3 irq not yet", {31'd0, ovf_irq}, 32'd0);
    step();
    chk("t3 irq set", {31'd0, ovf_irq}, 32'd1);
    wr(12'h325, 32'd1);
    rd(12'h325, d, h); chk("t3 evt5 cleared", d, 32'd1);
    step();
    chk("t3 irq clear", {31'd0, ovf_irq}, 32'd0);
    check_all("t3");

    // 4: CSR write beats a same-edge increment
    wr(12'h326, 32'd2);
    wr(12'hB06, 32'h10);
    step();
    wr(12'hB06, 32'h100);
    rd(12'hB06, d, h); chk("t4 write wins", d, 32'h100);
    step();
    rd(12'hB06, d, h); chk("t4 resumes", d, 32'h101);
    check_all("t4");

    // 5: WARL event field, read-only shadow, unmapped address
    wr(12'h327, 32'hFFFF_FFFF);
    rd(12'h327, d, h); chk("t5 evt7 warl", d, 32'h8000_001F);
    wr(12'hC07, 32'h1234_5678);
    rd(12'hB07, d, h); chk("t5 shadow write ignored", d, 32'd0);
    rd(12'h7C0, d, h);
    chk("t5 unmapped hit", {31'd0, h}, 32'd0);
    chk("t5 unmapped data", d, 32'd0);
    rd(12'h321, d, h); chk("t5 0x321 hit", {31'd0, h}, 32'd0);
    step();
    chk("t5 irq from OF7", {31'd0, ovf_irq}, 32'd1);
    check_all("t5");

    // 6: synchronous reset mid-count
    hpm_inc = 29'h1FFF_FFFF;
    inst_ret = 1'b1;
    repeat (4) step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    hpm_inc = 29'd0;
    inst_ret = 1'b0;
    chk("t6 irq", {31'd0, ovf_irq}, 32'd0);
    rd(12'hB04, d, h); chk("t6 cnt4", d, 32'd0);
    rd(12'h327, d, h); chk("t6 evt7", d, 32'd0);
    check_all("t6");

    // Randomized traffic: strobes every cycle, mixed CSR writes
    for (int i = 0; i < 256; i++) begin
      hpm_inc  = 29'($urandom);
      inst_ret = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      n = $urandom_range(3, 31);
      case (r)
        0:       wr(12'h320, $urandom & $urandom);
        1, 2:    wr(12'(32'h320 + n), $urandom);
        3, 4:    wr(12'(32'hB00 + n), 32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
        5:       wr(12'(32'hB80 + n), ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom);
        6:       wr(($urandom_range(0, 1) == 1) ? 12'(32'hC00 + n) : 12'(32'hC80 + n), $urandom);
        7:       wr(12'h7C0, $urandom);
        default: step();
      endcase
      if ((i % 16) == 15) check_all($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
